// File: rtl/arb_mux_stage.sv
// arb_mux_stage: NUM_CH-to-1 beat multiplexer with one registered output stage.
// An external round-robin arbiter supplies the grant. Each accepted beat is registered
// with its source channel index.
// Define ARB_MUX_PKT_LOCK_EN to hold the winning channel until its in_last beat.
// Without that macro, the stage re-arbitrates on every beat.
module arb_mux_stage #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_CH-1:0]         in_valid,
   input  logic [NUM_CH*DATA_W-1:0]  in_data,
   input  logic [NUM_CH-1:0]         in_last,
   output logic [NUM_CH-1:0]         in_ready,
   output logic [NUM_CH-1:0]         arb_valid,
   input  logic [NUM_CH-1:0]         arb_grant,
   output logic                      arb_next,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   output logic [$clog2(NUM_CH)-1:0] out_ch,
   input  logic                      out_ready
);

   localparam int CH_W = $clog2(NUM_CH);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t          state;
   logic [CH_W-1:0] lock_ch;
   logic [CH_W-1:0] sel;
   logic [CH_W-1:0] xfer_ch;
   logic            has_sel;
   logic            grab;
   logic            load_en;
   logic            xfer;
   logic            ends_arb;

   // The output register can take a new beat when it is empty or being drained.
   assign load_en = !out_valid || out_ready;
   assign has_sel = |arb_grant;

   // Pick the lowest set grant bit; the arbiter should send one-hot, but this keeps it defined.
   always_comb begin
      sel = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (arb_grant[i]) sel = CH_W'(i);
      end
   end

   // Choose the channel serviced this cycle: the granted one, or the locked one mid-packet.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      xfer_ch = sel;
      grab    = has_sel;
      if (state == LOCK) begin
         xfer_ch = lock_ch;
         grab    = 1'b1;
      end
   end

   // A beat moves only when the chosen channel is ready and valid; reset blocks all handshakes.
   assign xfer = rstn && load_en && grab && in_valid[xfer_ch];

   // Raise ready only for the single channel being serviced.
   always_comb begin
      in_ready = '0;
      if (rstn && load_en && grab) in_ready[xfer_ch] = 1'b1;
   end

   assign arb_valid = (rstn && load_en && state == IDLE) ? in_valid : '0;

`ifdef ARB_MUX_PKT_LOCK_EN
   // With packet locking, only the final beat of a packet releases the arbiter.
   assign ends_arb = in_last[xfer_ch];
`else
   // Without packet locking, every beat ends its own arbitration round.
   assign ends_arb = 1'b1;
`endif

   assign arb_next = xfer && ends_arb;

`ifdef ARB_MUX_PKT_LOCK_EN
   state_t          state_nxt;
   logic [CH_W-1:0] lock_ch_nxt;

   // Enter LOCK on a non-final beat; leave it on the final beat of the packet.
   always_comb begin
      state_nxt   = state;
      lock_ch_nxt = lock_ch;
      if (xfer) begin
         if (in_last[xfer_ch]) begin
            state_nxt = IDLE;
         end else begin
            state_nxt   = LOCK;
            lock_ch_nxt = xfer_ch;
         end
      end
   end

   // Lock state register; reset drops any packet in progress.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         lock_ch <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state   <= state_nxt;
         lock_ch <= lock_ch_nxt;
      end
   end
`else
   assign state   = IDLE;
   assign lock_ch = '0;
`endif

   // Output register: load on transfer, drop valid on a drain with no refill, else hold.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: payload registers are reset too, so the outputs read zero during reset.
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_ch    <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[int'(xfer_ch) * DATA_W +: DATA_W];
         out_last  <= in_last[xfer_ch];
         out_ch    <= xfer_ch;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
